// File: rtl/sqrt_pkg.sv
// Shared constants for the four-lane restoring square-root unit:
// FSM state encoding and a constant-width helper.
package sqrt_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bits needed to count 0 .. value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sqrt_lane.sv
// One combinational restoring square-root iteration: consumes the next
// radicand digit pair and produces one more root bit.
module sqrt_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       pair,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  localparam int TW = WIDTH + 3;

  logic [TW-1:0] r_shift;
  logic [TW-1:0] trial;
  logic [TW-1:0] t;
  logic          fits;

  // Wide enough that the true difference never wraps; top bit is the sign.
  always_comb begin
    r_shift = {r, pair};
    trial   = {1'b0, q, 2'b01};
    t       = r_shift - trial;
    fits    = ~t[TW-1];
    if (fits) begin
      r_next = (WIDTH+1)'(t);
    end else begin
      r_next = (WIDTH+1)'(r_shift);
    end
    q_next = (q << 1) | WIDTH'(fits);
  end

endmodule

// File: rtl/sqrt_complex_mag4.sv
// Four lock-step sequential integer square roots with valid/ready handshake;
// one root bit per lane per clock, WIDTH cycles of latency.
module sqrt_complex_mag4
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] ina,
  input  logic [2*WIDTH-1:0] inb,
  input  logic [2*WIDTH-1:0] inc,
  input  logic [2*WIDTH-1:0] ind,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   outa_root,
  output logic [WIDTH-1:0]   outb_root,
  output logic [WIDTH-1:0]   outc_root,
  output logic [WIDTH-1:0]   outd_root,
  output logic [WIDTH:0]     outa_rem,
  output logic [WIDTH:0]     outb_rem,
  output logic [WIDTH:0]     outc_rem,
  output logic [WIDTH:0]     outd_rem
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam int XW = 2 * WIDTH;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start;
  logic          step;

  logic [XW-1:0]    rad_in [4];
  logic [WIDTH-1:0] root_o [4];
  logic [WIDTH:0]   rem_o  [4];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          start   = 1'b1;
          cnt_d   = CW'(WIDTH - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  assign rad_in[0] = ina;
  assign rad_in[1] = inb;
  assign rad_in[2] = inc;
  assign rad_in[3] = ind;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [XW-1:0]    rad_q, rad_d;
      logic [WIDTH-1:0] root_q, root_d;
      logic [WIDTH:0]   rem_q, rem_d;
      logic [WIDTH-1:0] q_it;
      logic [WIDTH:0]   r_it;

      // The radicand shifts left so its top two bits are always the next digit pair.
      sqrt_lane #(.WIDTH(WIDTH)) u_lane (
        .r      (rem_q),
        .q      (root_q),
        .pair   (rad_q[XW-1 -: 2]),
        .r_next (r_it),
        .q_next (q_it)
      );

      always_comb begin
        rad_d  = rad_q;
        root_d = root_q;
        rem_d  = rem_q;
        if (start) begin
          rad_d  = rad_in[gi];
          root_d = '0;
          rem_d  = '0;
        end else if (step) begin
          rad_d  = rad_q << 2;
          root_d = q_it;
          rem_d  = r_it;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rad_q  <= '0;
          root_q <= '0;
          rem_q  <= '0;
        end else begin
          rad_q  <= rad_d;
          root_q <= root_d;
          rem_q  <= rem_d;
        end
      end

      assign root_o[gi] = root_q;
      assign rem_o[gi]  = rem_q;
    end
  endgenerate

  assign outa_root = root_o[0];
  assign outb_root = root_o[1];
  assign outc_root = root_o[2];
  assign outd_root = root_o[3];
  assign outa_rem  = rem_o[0];
  assign outb_rem  = rem_o[1];
  assign outc_rem  = rem_o[2];
  assign outd_rem  = rem_o[3];

endmodule

// File: tb/tb_sqrt_complex_mag4.sv
// Self-checking bench for sqrt_complex_mag4: directed corner cases plus
// randomized sets compared against a floating-point square-root reference.
module tb_sqrt_complex_mag4;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] x_in [4];
  logic [7:0]  root_o [4];
  logic [8:0]  rem_o [4];

  int n_checks = 0;
  int n_errors = 0;

  sqrt_complex_mag4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ina       (x_in[0]),
    .inb       (x_in[1]),
    .inc       (x_in[2]),
    .ind       (x_in[3]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outa_root (root_o[0]),
    .outb_root (root_o[1]),
    .outc_root (root_o[2]),
    .outd_root (root_o[3]),
    .outa_rem  (rem_o[0]),
    .outb_rem  (rem_o[1]),
    .outc_rem  (rem_o[2]),
    .outd_rem  (rem_o[3])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // floor(sqrt(x)) from real arithmetic, nudged to the exact integer answer.
  function automatic int ref_root(input int x);
    int r;
    r = int'($floor($sqrt(real'(x))));
    while (r > 0 && r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic check_results(input string tag, input logic [15:0] x[4], input bit print);
    int r [4];
    for (int l = 0; l < 4; l++) begin
      r[l] = ref_root(int'(x[l]));
      check($sformatf("%s_root%0d", tag, l), 32'(root_o[l]), r[l]);
      check($sformatf("%s_rem%0d", tag, l), 32'(rem_o[l]), int'(x[l]) - r[l] * r[l]);
    end
    if (print)
      $display("txn %s x=%0d,%0d,%0d,%0d root=%0d,%0d,%0d,%0d rem=%0d,%0d,%0d,%0d",
               tag, x[0], x[1], x[2], x[3], root_o[0], root_o[1], root_o[2], root_o[3],
               rem_o[0], rem_o[1], rem_o[2], rem_o[3]);
  endtask

  // Leaves the bench at the negedge just after the handshake edge.
  task automatic handshake(input string tag, input logic [15:0] x[4]);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    x_in     = x;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < WIDTH + 4);
    check({tag, "_latency"}, n, WIDTH);
    check({tag, "_out_valid"}, 32'(out_valid), 1);
  endtask

  task automatic drain(input string tag, input logic [15:0] x[4], input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 1);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 0);
      check_results({tag, "_hold"}, x, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 32'(out_valid), 0);
    check({tag, "_release_in_ready"}, 32'(in_ready), 1);
  endtask

  task automatic run_set(input string tag, input logic [15:0] x[4], input int hold);
    handshake(tag, x);
    wait_done(tag);
    check_results(tag, x, 1'b1);
    drain(tag, x, hold);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, "_no_output"}, 32'(out_valid), 0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] xa [4];
    logic [15:0] xb [4];
    logic [15:0] xr [4];
    int n;

    x_in = '{16'd0, 16'd0, 16'd0, 16'd0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 1);

    run_set("known", '{16'd0, 16'd1, 16'd144, 16'd200}, 0);
    run_set("max", '{16'd65535, 16'd65535, 16'd65535, 16'd65535}, 0);
    run_set("edges", '{16'd256, 16'd255, 16'd65535, 16'd65024}, 0);
    run_set("backpressure", '{16'd12345, 16'd4, 16'd3, 16'd50000}, 20);

    // New data offered mid-computation must not disturb the set in flight.
    xa = '{16'd1000, 16'd2, 16'd99, 16'd40000};
    xb = '{16'd5, 16'd6, 16'd7, 16'd8};
    handshake("busy_a", xa);
    repeat (2) @(negedge clk);
    check("busy_in_ready", 32'(in_ready), 0);
    x_in     = xb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_out_valid", 32'(out_valid), 1);
    check_results("busy_a", xa, 1'b1);
    drain("busy_a", xa, 0);
    run_set("busy_b", xb, 0);

    // Reset landing on the fourth iteration edge.
    handshake("rst_mid", xa);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", 32'(in_ready), 1);
    check("rst_mid_out_valid", 32'(out_valid), 0);
    watch_quiet("rst_mid", WIDTH + 2);
    run_set("after_rst", '{16'd81, 16'd82, 16'd80, 16'd1}, 0);

    // Reset and handshake on the same edge: nothing is latched.
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    x_in     = xa;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_hs_in_ready", 32'(in_ready), 1);
    check("rst_hs_out_valid", 32'(out_valid), 0);
    watch_quiet("rst_hs", WIDTH + 2);

    for (int s = 0; s < 600; s++) begin
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 3) == 0) begin
          int rr;
          rr = int'($urandom_range(1, 255));
          xr[l] = 16'(rr * rr - int'($urandom_range(0, 1)));
        end else begin
          xr[l] = 16'($urandom_range(0, 65535));
        end
      end
      run_set($sformatf("rand%0d", s), xr, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
